fifo_wr_arbiter: RTL and testbench

Write-port arbiter for the asynchronous FIFO write domain. It shares the single FIFO write port among `N_REQ` requesters in the `wclk` domain and drives the FIFO's `winc`/`wdata`. Grants rotate round-robin in bounded bursts of up to `MAX_BURST` words. It honours the registered `wfull` flag returned by the FIFO write-pointer logic.

---
 rtl/fifo_wr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the shared FIFO write port
//
// Shares one FIFO write port among N_REQ requesters in the wclk domain.
// Ownership is granted round-robin and lasts at most MAX_BURST accepted words.
// The registered wfull flag from the FIFO gates every write.
//
// Ports:
//   wclk       write-domain clock
//   wrst_n     asynchronous active-low reset
//   req        per-requester request, held high while the requester has a word
//   req_data   requester i's word at [i*DATA_W +: DATA_W]
//   wfull      registered FIFO full flag
//   gnt        one-hot accept strobe; the word is consumed at this edge
//   winc       FIFO write enable
//   wdata      FIFO write data (owner's slice)
//   owner      current or last owner index
//   busy       high while a burst is in progress
//   stall_cnt  saturating count of owner-requesting cycles blocked by wfull
//
// Build option: FIFO_WR_ARB_PRIO0_EN makes requester 0 strict-priority; the
// remaining requesters rotate round-robin among themselves.

module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic                       wfull,
    output logic [N_REQ-1:0]           gnt,
    output logic                       winc,
    output logic [DATA_W-1:0]          wdata,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic [15:0]                stall_cnt
);

    localparam int OWN_W  = $clog2(N_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [OWN_W-1:0]   rr_ptr;
    logic [OWN_W-1:0]   rr_nxt;
    logic [OWN_W-1:0]   owner_nxt;
    logic [BEAT_W-1:0]  beat;
    logic [BEAT_W-1:0]  beat_nxt;
    logic [15:0]        stall_nxt;

    logic [OWN_W-1:0]   pick;
    logic               pick_vld;
    logic [OWN_W-1:0]   cand;
    logic [OWN_W-1:0]   release_ptr;
    logic               owner_req;
    logic               accept;

    // Modular add on an index that need not be a power of two.
    function automatic logic [OWN_W-1:0] wrap_add(input logic [OWN_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return OWN_W'(s);
    endfunction

    assign owner_req = req[owner];
    assign accept    = (state == S_BURST) && owner_req && !wfull;

    // Rotating search from rr_ptr. Walking the offsets from the far end down
    // lets the nearest requesting index overwrite any farther one.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = wrap_add(rr_ptr, i);
`ifdef FIFO_WR_ARB_PRIO0_EN
            if (req[cand] && (cand != '0)) begin
`else
            if (req[cand]) begin
`endif
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (req[0]) begin
            pick     = '0;
            pick_vld = 1'b1;
        end
`endif
    end

    // Pointer to load when the current burst ends.
    always_comb begin
        release_ptr = wrap_add(owner, 1);
`ifdef FIFO_WR_ARB_PRIO0_EN
        // Priority bursts leave the rotation among the others untouched.
        if (owner == '0) begin
            release_ptr = rr_ptr;
        end
`endif
    end

    // State register
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            beat      <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_nxt;
            beat      <= beat_nxt;
            stall_cnt <= stall_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat;
        stall_nxt = stall_cnt;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt = S_BURST;
                    owner_nxt = pick;
                    beat_nxt  = '0;
                end
            end
            S_BURST: begin
                if (!owner_req) begin
                    state_nxt = S_IDLE;
                    rr_nxt    = release_ptr;
                end else if (wfull) begin
                    if (stall_cnt != 16'hFFFF) begin
                        stall_nxt = stall_cnt + 16'd1;
                    end
                end else begin
                    beat_nxt = beat + BEAT_W'(1);
                    if (beat == LAST_BEAT) begin
                        state_nxt = S_IDLE;
                        rr_nxt    = release_ptr;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs: only the owner's request and data reach the write port.
    always_comb begin
        gnt = '0;
        if (accept) begin
            gnt[owner] = 1'b1;
        end
        winc  = accept;
        wdata = req_data[int'(owner)*DATA_W +: DATA_W];
        busy  = (state == S_BURST);
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            wclk = 1'b0;
    logic            wrst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            wfull;
    logic [N-1:0]    gnt;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [1:0]      owner;
    logic            busy;
    logic [15:0]     stall_cnt;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req       (req),
        .req_data  (req_data),
        .wfull     (wfull),
        .gnt       (gnt),
        .winc      (winc),
        .wdata     (wdata),
        .owner     (owner),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [N-1:0]  gnt;
        logic          winc;
        logic [DW-1:0] wdata;
        int            owner;
        logic          busy;
        int            stall;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: who owns the port, how many words are taken, where
    // the rotation resumes, and how many blocked cycles were seen.
    bit m_busy;
    int m_owner, m_rr, m_taken, m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int choose(input logic [N-1:0] r);
        int j;
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int i = 0; i < N; i++) begin
            j = (m_rr + i) % N;
`ifdef FIFO_WR_ARB_PRIO0_EN
            if (j == 0) continue;
`endif
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic void end_burst();
        m_busy = 1'b0;
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (m_owner != 0) m_rr = (m_owner + 1) % N;
`else
        m_rr = (m_owner + 1) % N;
`endif
    endfunction

    // Advances the model across one rising edge with the inputs then present.
    function automatic void model_clock();
        int c;
        if (!wrst_n) begin
            m_busy = 1'b0; m_owner = 0; m_rr = 0; m_taken = 0; m_stall = 0;
        end else if (!m_busy) begin
            c = choose(req);
            if (c >= 0) begin
                m_busy = 1'b1; m_owner = c; m_taken = 0;
            end
        end else if (!req[m_owner]) begin
            end_burst();
        end else if (wfull) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            m_taken++;
            if (m_taken == MB) end_burst();
        end
    endfunction

    function automatic void push_expect();
        exp_t e;
        e.winc  = m_busy && req[m_owner] && !wfull;
        e.gnt   = e.winc ? (N'(1) << m_owner) : '0;
        e.wdata = req_data[m_owner*DW +: DW];
        e.owner = m_owner;
        e.busy  = m_busy;
        e.stall = m_stall;
        sb.push_back(e);
    endfunction

    task automatic cycle(input logic [N-1:0] r, input logic wf);
        @(posedge wclk);
        model_clock();
        #1;
        req      = r;
        wfull    = wf;
        req_data = $urandom;
        push_expect();
    endtask

    // Monitor: compares the DUT against the oldest expectation each cycle.
    always @(negedge wclk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("gnt",       32'(gnt),       32'(e.gnt));
            chk("winc",      32'(winc),      32'(e.winc));
            chk("wdata",     32'(wdata),     32'(e.wdata));
            chk("owner",     32'(owner),     32'(e.owner));
            chk("busy",      32'(busy),      32'(e.busy));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
        end
    end

    // Asserts reset between edges and checks the outputs drop at once.
    task automatic mid_reset();
        @(negedge wclk);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("rst_gnt",   32'(gnt),       32'h0);
        chk("rst_winc",  32'(winc),      32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
    endtask

    task automatic release_reset();
        @(negedge wclk);
        #2;
        wrst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        int           full_run;

        wrst_n = 1'b0; req = '0; wfull = 1'b0; req_data = '0;
        m_busy = 1'b0; m_owner = 0; m_rr = 0; m_taken = 0; m_stall = 0;
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        release_reset();

        // Reset mid-burst, then the first grant after release goes to 0.
        repeat (3) cycle(4'b0011, 1'b0);
        mid_reset();
        repeat (2) cycle(4'b0011, 1'b0);
        release_reset();
        repeat (6) cycle(4'b0011, 1'b0);

        // Full rotation from a clean pointer.
        mid_reset();
        cycle(4'b1111, 1'b0);
        release_reset();
        repeat (25) cycle(4'b1111, 1'b0);

        // Five-cycle full stall inside a burst.
        repeat (2) cycle(4'b1111, 1'b0);
        repeat (5) cycle(4'b1111, 1'b1);
        repeat (8) cycle(4'b1111, 1'b0);

        // Early release by requester 2, then wrap-around with only req[1].
        repeat (4) cycle(4'b0100, 1'b0);
        repeat (6) cycle(4'b1000, 1'b0);
        repeat (8) cycle(4'b0010, 1'b0);

        // Randomised requests with held levels and runs of wfull.
        r = 4'b1111;
        full_run = 0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) r[i] = ~r[i];
            end
            if (full_run > 0) begin
                full_run--;
            end else if ($urandom_range(9) == 0) begin
                full_run = $urandom_range(6, 1);
            end
            cycle(r, full_run > 0);
            if (k == 700) begin
                mid_reset();
                cycle(r, 1'b0);
                release_reset();
            end
        end

        @(negedge wclk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
